// File: rtl/matmul_mem_port.sv
// matmul_mem_port
// ---------------
// Memory-side stage behind the matmul engine. One single-port synchronous
// SRAM is shared between the engine request port and a host load/unload
// port. The engine has no stall input, so it always wins. The host is
// granted only in cycles where the engine is idle. Read data returns in
// issue order, SRAM_LAT+1 cycles after the access cycle.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_req/write/addr/wdata engine access (one per cycle while mem_req)
//   mem_rdata_vld/mem_rdata  engine read return
//   host_req/write/addr/wdata host access, held until host_gnt
//   host_gnt                 host access accepted this cycle
//   host_rdata_vld/host_rdata host read return
//   sram_ce/we/addr/wdata    SRAM command, sram_rdata SRAM read data
//   cnt_clr                  synchronous clear of the activity counters
//   eng_rd_cnt, eng_wr_cnt   engine reads/writes issued (wrapping)
//   host_wait_cnt            host stall cycles (saturating)
`timescale 1ns/1ps

module matmul_mem_port #(
   parameter int MEM_AW   = 16,
   parameter int MEM_DW   = 32,
   parameter int SRAM_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_req,
   input  logic              mem_write,
   input  logic [MEM_AW-1:0] mem_addr,
   input  logic [MEM_DW-1:0] mem_wdata,
   output logic              mem_rdata_vld,
   output logic [MEM_DW-1:0] mem_rdata,
   input  logic              host_req,
   input  logic              host_write,
   input  logic [MEM_AW-1:0] host_addr,
   input  logic [MEM_DW-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rdata_vld,
   output logic [MEM_DW-1:0] host_rdata,
   output logic              sram_ce,
   output logic              sram_we,
   output logic [MEM_AW-1:0] sram_addr,
   output logic [MEM_DW-1:0] sram_wdata,
   input  logic [MEM_DW-1:0] sram_rdata,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  eng_rd_cnt,
   output logic [CNT_W-1:0]  eng_wr_cnt,
   output logic [CNT_W-1:0]  host_wait_cnt
);

   // Configuration guard: the return pipeline is only defined for 1..4.
   generate
      if (SRAM_LAT < 1 || SRAM_LAT > 4) begin : g_bad_sram_lat
         $error("matmul_mem_port: SRAM_LAT must be in 1..4");
      end
   endgenerate

   logic              eng_sel_s;
   logic              host_sel_s;

   logic [MEM_AW-1:0] addr_q,  addr_d;
   logic [MEM_DW-1:0] wdata_q, wdata_d;

   // Return tag pipeline: valid and owner (0 engine, 1 host) per stage.
   logic [SRAM_LAT-1:0] pv_q, pv_d;
   logic [SRAM_LAT-1:0] po_q, po_d;

   logic              mem_vld_q,    mem_vld_d;
   logic              host_vld_q,   host_vld_d;
   logic [MEM_DW-1:0] mem_rdata_q,  mem_rdata_d;
   logic [MEM_DW-1:0] host_rdata_q, host_rdata_d;

   logic [CNT_W-1:0]  eng_rd_q,    eng_rd_d;
   logic [CNT_W-1:0]  eng_wr_q,    eng_wr_d;
   logic [CNT_W-1:0]  host_wait_q, host_wait_d;

   // Arbitration: engine first, host only when the engine is idle. Gated by
   // rst_n so the SRAM command and grant are quiet while reset is held.
   // Address/data hold their last driven value in idle cycles.
   always_comb begin
      eng_sel_s  = mem_req & rst_n;
      host_sel_s = host_req & ~mem_req & rst_n;
      if (eng_sel_s) begin
         sram_ce    = 1'b1;
         sram_we    = mem_write;
         sram_addr  = mem_addr;
         sram_wdata = mem_wdata;
      end else if (host_sel_s) begin
         sram_ce    = 1'b1;
         sram_we    = host_write;
         sram_addr  = host_addr;
         sram_wdata = host_wdata;
      end else begin
         sram_ce    = 1'b0;
         sram_we    = 1'b0;
         sram_addr  = addr_q;
         sram_wdata = wdata_q;
      end
      host_gnt = host_sel_s;
      addr_d   = sram_addr;
      wdata_d  = sram_wdata;
   end

   // Return tag shift register: stage 0 captures this cycle's read, if any.
   always_comb begin
      pv_d    = pv_q;
      po_d    = po_q;
      pv_d[0] = sram_ce & ~sram_we;
      po_d[0] = host_sel_s;
      for (int i = 1; i < SRAM_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
      end
   end

   // Last tag stage lines up with valid sram_rdata; steer it to its owner.
   // Each read data register holds while its valid is low.
   always_comb begin
      mem_vld_d  = pv_q[SRAM_LAT-1] & ~po_q[SRAM_LAT-1];
      host_vld_d = pv_q[SRAM_LAT-1] &  po_q[SRAM_LAT-1];
      if (mem_vld_d) begin
         mem_rdata_d = sram_rdata;
      end else begin
         mem_rdata_d = mem_rdata_q;
      end
      if (host_vld_d) begin
         host_rdata_d = sram_rdata;
      end else begin
         host_rdata_d = host_rdata_q;
      end
   end

   // Activity counters; clear wins over increment in the same cycle.
   always_comb begin
      if (cnt_clr) begin
         eng_rd_d    = {CNT_W{1'b0}};
         eng_wr_d    = {CNT_W{1'b0}};
         host_wait_d = {CNT_W{1'b0}};
      end else begin
         if (mem_req & ~mem_write) begin
            eng_rd_d = eng_rd_q + CNT_W'(1);
         end else begin
            eng_rd_d = eng_rd_q;
         end
         if (mem_req & mem_write) begin
            eng_wr_d = eng_wr_q + CNT_W'(1);
         end else begin
            eng_wr_d = eng_wr_q;
         end
         // Saturate at all-ones so a long starvation stays visible.
         if (host_req & ~host_sel_s & ~(&host_wait_q)) begin
            host_wait_d = host_wait_q + CNT_W'(1);
         end else begin
            host_wait_d = host_wait_q;
         end
      end
   end

   // State registers; reset discards any in-flight read tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= {MEM_AW{1'b0}};
         wdata_q      <= {MEM_DW{1'b0}};
         pv_q         <= {SRAM_LAT{1'b0}};
         po_q         <= {SRAM_LAT{1'b0}};
         mem_vld_q    <= 1'b0;
         host_vld_q   <= 1'b0;
         mem_rdata_q  <= {MEM_DW{1'b0}};
         host_rdata_q <= {MEM_DW{1'b0}};
         eng_rd_q     <= {CNT_W{1'b0}};
         eng_wr_q     <= {CNT_W{1'b0}};
         host_wait_q  <= {CNT_W{1'b0}};
      end else begin
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pv_q         <= pv_d;
         po_q         <= po_d;
         mem_vld_q    <= mem_vld_d;
         host_vld_q   <= host_vld_d;
         mem_rdata_q  <= mem_rdata_d;
         host_rdata_q <= host_rdata_d;
         eng_rd_q     <= eng_rd_d;
         eng_wr_q     <= eng_wr_d;
         host_wait_q  <= host_wait_d;
      end
   end

   assign mem_rdata_vld  = mem_vld_q;
   assign mem_rdata      = mem_rdata_q;
   assign host_rdata_vld = host_vld_q;
   assign host_rdata     = host_rdata_q;
   assign eng_rd_cnt     = eng_rd_q;
   assign eng_wr_cnt     = eng_wr_q;
   assign host_wait_cnt  = host_wait_q;

endmodule

// File: doc/matmul_mem_port.md
Name: matmul_mem_port

Overview:
- Memory-side stage directly downstream of the matmul engine. Serves the engine's request interface (mem_req/mem_write/mem_addr/mem_wdata -> mem_rdata_vld/mem_rdata) from one single-port synchronous SRAM.
- Arbitrates a secondary host port used to load operand matrices and unload results.
- The engine has no stall input, so the engine always wins. The host is granted only in cycles where the engine is idle.
- Read data is returned in order with a fixed latency. Saturating and wrapping activity counters support bring-up.

Parameters:
- MEM_AW, 16, address width (engine, host and SRAM).
- MEM_DW, 32, data width.
- SRAM_LAT, 1, SRAM read latency in cycles from sram_ce to valid sram_rdata; legal range 1..4.
- CNT_W, 32, width of the activity counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assertion, active low.
- mem_req  in  1  engine access request, one access per cycle while high.
- mem_write  in  1  engine access type: 1 = write, 0 = read.
- mem_addr  in  MEM_AW  engine word address.
- mem_wdata  in  MEM_DW  engine write data.
- mem_rdata_vld  out  1  engine read data valid, one-cycle pulse per read.
- mem_rdata  out  MEM_DW  engine read data.
- host_req  in  1  host access request; held until granted.
- host_write  in  1  host access type: 1 = write, 0 = read.
- host_addr  in  MEM_AW  host word address.
- host_wdata  in  MEM_DW  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rdata_vld  out  1  host read data valid.
- host_rdata  out  MEM_DW  host read data.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  MEM_AW  SRAM address.
- sram_wdata  out  MEM_DW  SRAM write data.
- sram_rdata  in  MEM_DW  SRAM read data.
- cnt_clr  in  1  synchronous clear of all counters.
- eng_rd_cnt  out  CNT_W  engine reads issued, wrapping.
- eng_wr_cnt  out  CNT_W  engine writes issued, wrapping.
- host_wait_cnt  out  CNT_W  cycles with host_req high and host_gnt low, saturating at all-ones.

Behaviour:
- Reset values: every output is 0, including counters and read-return pipeline valids.
- Reset mid-operation: in-flight reads are discarded and no vld pulse is produced for them.
- Arbitration (combinational, per cycle):
  - mem_req=1: engine owns the SRAM. sram_ce=1, sram_we=mem_write, sram_addr=mem_addr, sram_wdata=mem_wdata.
  - mem_req=0 and host_req=1: host owns the SRAM and host_gnt=1; SRAM fields are driven from the host_* inputs.
  - Neither requesting: sram_ce=0, sram_we=0, addr/wdata hold their previous values.
- host_gnt = host_req & ~mem_req. The host must hold its request fields stable until host_gnt. Host starvation under continuous engine traffic is permitted; host_wait_cnt exposes it.
- Read return pipeline, SRAM_LAT+1 stages, shift register of {valid, owner}:
  - Stage 0 loads {sram_ce & ~sram_we, owner}; owner = 0 engine, 1 host.
  - sram_rdata is sampled when the tag reaches stage SRAM_LAT and is registered to the outputs.
  - The matching vld pulses exactly SRAM_LAT+1 cycles after the access cycle: 2 cycles at default.
  - Engine reads drive mem_rdata_vld/mem_rdata; host reads drive host_rdata_vld/host_rdata.
- Return ordering and data hold:
  - Returns are strictly in issue order, and at most one vld (engine or host) is high per cycle.
  - mem_rdata and host_rdata hold their last value when their vld is low.
- Back-to-back reads, one per cycle, are sustained with no bubbles and produce consecutive vld pulses.
- Writes take effect in the SRAM at the access cycle and return nothing. A read of the same address in the next cycle returns the new data; the SRAM is write-first.
- Counters:
  - eng_rd_cnt increments on mem_req & ~mem_write.
  - eng_wr_cnt increments on mem_req & mem_write.
  - Both wrap at 2^CNT_W.
  - cnt_clr has priority over increment in the same cycle.
- Simultaneous engine and host requests: engine is served, host_gnt=0, host_wait_cnt increments.
- SRAM_LAT outside 1..4 is a configuration error and is flagged by an elaboration-time check.

Test Plan:
- Host write fill: host writes addr 0..7 with data 0x100+i, engine idle -> 8 host_gnt pulses in 8 cycles, SRAM holds the data, all counters 0 except host_wait_cnt=0.
- Engine streaming read: mem_req=1 read addr 0..7 for 8 consecutive cycles, SRAM_LAT=1 -> mem_rdata_vld high on cycles 2..9 with 0x100..0x107 in order; eng_rd_cnt=8.
- Contention: host_req read addr 3 held during a 5-cycle engine burst -> host_gnt only in the first cycle after mem_req drops, host_rdata=0x103 two cycles later, host_wait_cnt=5, no engine vld disturbed.
- Write then read: engine writes 0xDEADBEEF to addr 0x20, then reads 0x20 next cycle -> mem_rdata=0xDEADBEEF; eng_wr_cnt=1, eng_rd_cnt=1.
- Reset mid-flight: assert rst_n low one cycle after issuing 2 engine reads -> no mem_rdata_vld pulses afterward, all outputs 0 during reset. Repeat the streaming test with SRAM_LAT=3 -> latency 4.
- Counter edges: preload eng_rd_cnt to all-ones via 2^CNT_W reads (CNT_W=4 build) -> wraps to 0. host_wait_cnt saturates at 15. cnt_clr with a simultaneous read -> counter reads 0.
